ibus_prefetch_master: RTL and testbench
=======================================

Name: ibus_prefetch_master

Overview:
- Parametrised successor to the CPU's single-word instruction bus master.
- Fetches sequential instruction words ahead of the decode stage into a DEPTH-entry prefetch queue, tagging each word with its PC.
- Supports redirect (branch/jump) with queue flush and discard of an in-flight bus read.
- Sits between the PC/fetch logic and the IBus; presents a valid/ready instruction stream to decode.

Parameters:
- ADDR_W, 30, IBus word-address width; byte PC bits [ADDR_W+1:2] drive the bus.
- DEPTH, 4, prefetch queue entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, byte PC fetched first after reset; bits [1:0] must be 0.

Ports:
- i_Clk  in  1  clock, rising edge.
- i_Rst  in  1  asynchronous, active-high reset.
- o_IBus_Address  out  ADDR_W  word address of current read.
- o_IBus_Read  out  1  read request.
- i_IBus_ReadData  in  32  read data, valid when o_IBus_Read=1 and i_IBus_WaitReq=0.
- i_IBus_WaitReq  in  1  slave stall.
- i_Redirect  in  1  one-cycle pulse: flush and fetch from i_RedirectPc.
- i_RedirectPc  in  32  new byte PC; bits [1:0] ignored, treated as 0.
- o_InstValid  out  1  queue head valid.
- o_Inst  out  32  queue head instruction.
- o_InstPc  out  32  byte PC of o_Inst.
- i_InstReady  in  1  decode accepts head this cycle.
- o_Count  out  $clog2(DEPTH+1)  queue occupancy.

Behaviour:
- Reset (async, held or mid-operation): queue empty; o_Count=0; o_InstValid=0; o_Inst=0; o_InstPc=0; fetch PC=RESET_PC; state FETCH; o_IBus_Read=0 while i_Rst=1. An in-flight bus read is abandoned; the bus is reset by the same signal.
- States:
  - FETCH: o_IBus_Read=1 when o_Count<DEPTH.
  - DISCARD: o_IBus_Read=1 always, holding the old address.
- Bus protocol:
  - Address is registered and held stable while o_IBus_Read=1 and i_IBus_WaitReq=1.
  - A transfer completes in a cycle where o_IBus_Read=1 and i_IBus_WaitReq=0.
  - Once asserted, o_IBus_Read is never dropped before completion. Full cannot become true during a wait, since only pops occur.
- FETCH completion: push {ReadData, fetch PC}; fetch PC += 4 (32-bit wrap, 0xFFFFFFFC -> 0).
- Pop: on o_InstValid && i_InstReady, head advances at the clock edge. Push and pop in the same cycle leave o_Count unchanged; a push while full is impossible by construction.
- Latency: a word returned at edge N is visible on o_Inst at cycle N+1. This gives back-to-back throughput of 1 instruction/cycle when WaitReq=0 and ready=1.
- Redirect (highest priority over push and pop that cycle):
  - Queue flushed: o_Count=0 and o_InstValid=0 next cycle.
  - Any pop that cycle is ignored.
  - Read idle, or completing this cycle (WaitReq=0): returned data is dropped; next cycle FETCH issues i_RedirectPc[ADDR_W+1:2].
  - Read pending (Read=1, WaitReq=1): go to DISCARD and latch the new PC.
- DISCARD:
  - On completion, data is dropped and the state returns to FETCH. The next cycle issues the latched PC.
  - A further redirect in DISCARD overwrites the latched PC and stays in DISCARD.
- o_Inst/o_InstPc hold their last value when the queue is empty. Only o_InstValid is qualifying.

Optional Feature:
- Macro IBUS_PREFETCH_BYPASS_EN.
- Defined: when the queue is empty, state is FETCH, and a read completes this cycle, the data and PC are driven combinationally onto o_Inst/o_InstPc with o_InstValid=1 in that same cycle.
  - If i_InstReady=1, the word is consumed and not pushed.
  - Redirect the same cycle suppresses the bypass.
- Not defined: no combinational path from i_IBus_ReadData to outputs; latency as above.

Test Plan:
- Reset release, RESET_PC=0x100, WaitReq=0, ready=1 -> addresses 0x40,0x41,0x42…; o_InstValid first at cycle 1 with o_InstPc=0x100, then 0x104, 0x108 on consecutive cycles.
- ready=0, WaitReq=0, DEPTH=4 -> exactly 4 reads complete; o_Count=4; o_IBus_Read=0 thereafter. Raise ready for 1 cycle -> one more read issued, o_Count returns to 4.
- WaitReq=1 for 3 cycles on address 0x45 -> address held at 0x45 for all 4 cycles; one push only.
- Redirect to 0x2000 while read of 0x45 is stalled (WaitReq=1 for 2 more cycles) -> o_Count=0 next cycle; 0x45 completes and is dropped; next address 0x800; first o_InstPc=0x2000.
- Redirect to 0x3002 coincident with completion and pop -> data dropped, pop ignored; next address 0xC00; o_InstPc=0x3000.
- With IBUS_PREFETCH_BYPASS_EN, empty queue, WaitReq=0, ready=1 -> o_InstValid=1 in the same cycle as completion; o_Count stays 0.

Source files
------------

// File: rtl/ibus_prefetch_master.sv
// rtl/ibus_prefetch_master.sv - sequential instruction prefetch master for the IBus
//
// Fetches instruction words ahead of decode into a DEPTH-entry queue and tags
// each word with its byte PC. A redirect flushes the queue. A bus read already
// stalled when the redirect arrives is finished and its data is thrown away.
//
// Optional macro IBUS_PREFETCH_BYPASS_EN: when the queue is empty, a word that
// completes in FETCH is also driven straight onto o_Inst/o_InstPc in the same
// cycle.
//
// Ports:
//   i_Clk, i_Rst            clock (rising edge), asynchronous active-high reset
//   o_IBus_Address/Read     word address and read request to the IBus
//   i_IBus_ReadData/WaitReq read data and slave stall
//   i_Redirect/RedirectPc   one-cycle flush pulse and new byte PC
//   o_InstValid/Inst/InstPc queue head presented to decode
//   i_InstReady             decode accepts the head this cycle
//   o_Count                 queue occupancy
module ibus_prefetch_master #(
  parameter int          ADDR_W   = 30,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst,
  output logic [ADDR_W-1:0]            o_IBus_Address,
  output logic                         o_IBus_Read,
  input  logic [31:0]                  i_IBus_ReadData,
  input  logic                         i_IBus_WaitReq,
  input  logic                         i_Redirect,
  input  logic [31:0]                  i_RedirectPc,
  output logic                         o_InstValid,
  output logic [31:0]                  o_Inst,
  output logic [31:0]                  o_InstPc,
  input  logic                         i_InstReady,
  output logic [$clog2(DEPTH+1)-1:0]   o_Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic {S_FETCH, S_DISCARD} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  // In FETCH: PC of the word at addr_q. In DISCARD: the latched redirect PC.
  logic [31:0]        fetch_pc;
  logic [31:0]        next_pc;
  logic [31:0]        inst_mem [DEPTH];
  logic [31:0]        pc_mem   [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr, rd_next;
  logic [CNT_W-1:0]   count_q;
  logic [31:0]        head_inst, head_pc;

  logic bus_read, done, stalled, push, pop, bypass;

  assign next_pc = fetch_pc + 32'd4;
  assign rd_next = rd_ptr + 1'b1;

  always_comb begin
    state_d  = state_q;
    bus_read = (state_q == S_DISCARD) || (count_q < FULL);
    done     = bus_read && !i_IBus_WaitReq;
    stalled  = bus_read && i_IBus_WaitReq;
    bypass   = 1'b0;
`ifdef IBUS_PREFETCH_BYPASS_EN
    bypass   = (state_q == S_FETCH) && (count_q == '0) && done && !i_Redirect;
`endif
    pop      = (count_q != '0) && i_InstReady && !i_Redirect;
    // A bypassed word that decode takes immediately never enters the queue.
    push     = (state_q == S_FETCH) && done && !i_Redirect && !(bypass && i_InstReady);
    if (i_Redirect) begin
      state_d = stalled ? S_DISCARD : S_FETCH;
    end else if (state_q == S_DISCARD && done) begin
      state_d = S_FETCH;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      addr_q   <= RESET_PC[ADDR_W+1:2];
      fetch_pc <= RESET_PC;
    end else if (i_Redirect) begin
      fetch_pc <= {i_RedirectPc[31:2], 2'b00};
      // A stalled read keeps its address until it completes.
      if (!stalled) addr_q <= i_RedirectPc[ADDR_W+1:2];
    end else if (done) begin
      if (state_q == S_FETCH) begin
        fetch_pc <= next_pc;
        addr_q   <= next_pc[ADDR_W+1:2];
      end else begin
        addr_q   <= fetch_pc[ADDR_W+1:2];
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= i_IBus_ReadData;
      pc_mem[wr_ptr]   <= fetch_pc;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count_q   <= '0;
      head_inst <= '0;
      head_pc   <= '0;
    end else if (i_Redirect) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_next;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
      // Head registers hold the last shown word once the queue drains.
      if (pop && count_q > CNT_W'(1)) begin
        head_inst <= inst_mem[rd_next];
        head_pc   <= pc_mem[rd_next];
      end else if (push && (count_q == '0 || (pop && count_q == CNT_W'(1)))) begin
        head_inst <= i_IBus_ReadData;
        head_pc   <= fetch_pc;
      end
    end
  end

  assign o_IBus_Read    = bus_read && !i_Rst;
  assign o_IBus_Address = addr_q;
  assign o_Count        = count_q;
  assign o_InstValid    = (count_q != '0) || bypass;
  assign o_Inst         = bypass ? i_IBus_ReadData : head_inst;
  assign o_InstPc       = bypass ? fetch_pc : head_pc;

endmodule

// File: tb/tb_ibus_prefetch_master.sv
// tb/tb_ibus_prefetch_master.sv - randomized bench with queue-based reference model
module tb_ibus_prefetch_master;

  localparam int          ADDR_W   = 30;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic                       i_Clk = 1'b0;
  logic                       i_Rst = 1'b1;
  logic [ADDR_W-1:0]          o_IBus_Address;
  logic                       o_IBus_Read;
  logic [31:0]                i_IBus_ReadData = '0;
  logic                       i_IBus_WaitReq = 1'b0;
  logic                       i_Redirect = 1'b0;
  logic [31:0]                i_RedirectPc = '0;
  logic                       o_InstValid;
  logic [31:0]                o_Inst;
  logic [31:0]                o_InstPc;
  logic                       i_InstReady = 1'b0;
  logic [$clog2(DEPTH+1)-1:0] o_Count;

  ibus_prefetch_master #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst),
    .o_IBus_Address(o_IBus_Address), .o_IBus_Read(o_IBus_Read),
    .i_IBus_ReadData(i_IBus_ReadData), .i_IBus_WaitReq(i_IBus_WaitReq),
    .i_Redirect(i_Redirect), .i_RedirectPc(i_RedirectPc),
    .o_InstValid(o_InstValid), .o_Inst(o_Inst), .o_InstPc(o_InstPc),
    .i_InstReady(i_InstReady), .o_Count(o_Count)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  // Reference model: a plain queue of tagged words plus the bus view.
  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  logic        m_discard;
  logic [31:0] m_last_inst, m_last_pc;

  int vec_count = 0;
  int err_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc        = RESET_PC;
    m_addr      = RESET_PC >> 2;
    m_discard   = 1'b0;
    m_last_inst = '0;
    m_last_pc   = '0;
  endtask

  task automatic check_reset_outputs();
    check("rst_read",  {31'b0, o_IBus_Read}, 32'd0);
    check("rst_count", 32'(o_Count), 32'd0);
    check("rst_valid", {31'b0, o_InstValid}, 32'd0);
    check("rst_inst",  o_Inst, 32'd0);
    check("rst_pc",    o_InstPc, 32'd0);
  endtask

  // Asynchronous reset asserted mid-cycle, held two edges, released after an edge.
  task automatic do_reset();
    #2 i_Rst = 1'b1;
    i_Redirect = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(posedge i_Clk);
    #1 check_reset_outputs();
    model_reset();
    i_Rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare at the negedge, advance the model.
  task automatic step(input bit wr, input bit rdy, input bit redir, input logic [31:0] rpc);
    bit          exp_read, comp, byp, exp_valid;
    logic [31:0] data, exp_inst, exp_ipc;
    data            = $urandom;
    i_IBus_WaitReq  = wr;
    i_InstReady     = rdy;
    i_Redirect      = redir;
    i_RedirectPc    = rpc;
    i_IBus_ReadData = data;
    @(negedge i_Clk);

    exp_read = m_discard || (mq.size() < DEPTH);
    comp     = exp_read && !wr;
    byp      = 1'b0;
`ifdef IBUS_PREFETCH_BYPASS_EN
    byp      = !m_discard && (mq.size() == 0) && comp && !redir;
`endif
    exp_valid = (mq.size() > 0) || byp;
    if (byp) begin
      exp_inst = data;
      exp_ipc  = m_pc;
    end else if (mq.size() > 0) begin
      exp_inst = mq[0].inst;
      exp_ipc  = mq[0].pc;
    end else begin
      exp_inst = m_last_inst;
      exp_ipc  = m_last_pc;
    end

    check("read",  {31'b0, o_IBus_Read}, {31'b0, exp_read});
    if (exp_read) check("addr", 32'(o_IBus_Address), {2'b00, m_addr[ADDR_W-1:0]});
    check("count", 32'(o_Count), mq.size());
    check("valid", {31'b0, o_InstValid}, {31'b0, exp_valid});
    check("inst",  o_Inst, exp_inst);
    check("ipc",   o_InstPc, exp_ipc);

    if (redir) begin
      mq.delete();
      if (exp_read && wr) begin
        m_discard = 1'b1;
      end else begin
        m_discard = 1'b0;
        m_addr    = rpc >> 2;
      end
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (rdy && mq.size() > 0) void'(mq.pop_front());
      if (comp) begin
        if (m_discard) begin
          m_discard = 1'b0;
          m_addr    = m_pc >> 2;
        end else begin
          if (!(byp && rdy)) mq.push_back('{inst: data, pc: m_pc});
          m_pc   = m_pc + 32'd4;
          m_addr = m_pc >> 2;
        end
      end
    end
    if (mq.size() > 0) begin
      m_last_inst = mq[0].inst;
      m_last_pc   = mq[0].pc;
    end

    @(posedge i_Clk);
    #1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge i_Clk);
    #1 check_reset_outputs();
    i_Rst = 1'b0;

    // Streaming from RESET_PC with no stalls.
    repeat (6) step(0, 1, 0, 0);
    // Fill to DEPTH, then a single-cycle pop.
    repeat (7) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    // Drain, then a stalled read held for three cycles.
    repeat (5) step(1, 1, 0, 0);
    repeat (3) step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    // Redirect during a stall: the stalled word must be dropped.
    step(1, 1, 1, 32'h0000_2000);
    repeat (2) step(1, 1, 0, 0);
    repeat (4) step(0, 1, 0, 0);
    // Redirect coincident with completion and pop; unaligned target.
    step(0, 1, 1, 32'h0000_3002);
    repeat (4) step(0, 1, 0, 0);
    // Redirect again while already discarding.
    step(1, 0, 1, 32'h0000_4000);
    step(1, 0, 1, 32'h0000_5000);
    repeat (6) step(0, 0, 0, 0);
    // PC wrap at the top of the address space.
    step(0, 1, 1, 32'hFFFF_FFF8);
    repeat (5) step(0, 1, 0, 0);
    // Reset while operating.
    do_reset();
    repeat (4) step(0, 1, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0, $urandom);
      if (i == 1500) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
